// File: rtl/pc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_pkg : shared types and control decode for the program counter
// Revision: 1.0
// ---------------------------------------------------------------------------
package pc_pkg;

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_START,
      OP_RET,
      OP_CALL,
      OP_LOAD,
      OP_BRANCH,
      OP_INC
   } pc_op_t;

   localparam int STACK_DEPTH_DEF = 4;
   localparam int DEPTH_W         = $clog2(STACK_DEPTH_DEF + 1);

   function automatic int depth_bits(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Stall outranks every action except start, so it decodes to a plain hold.
   function automatic pc_op_t decode_op(input logic start, input logic stall,
                                        input logic ret, input logic call,
                                        input logic load, input logic branch,
                                        input logic inc_pc);
      if (start)       return OP_START;
      else if (stall)  return OP_HOLD;
      else if (ret)    return OP_RET;
      else if (call)   return OP_CALL;
      else if (load)   return OP_LOAD;
      else if (branch) return OP_BRANCH;
      else if (inc_pc) return OP_INC;
      else             return OP_HOLD;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_ret_stack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_ret_stack : LIFO of return addresses; ignores push-when-full/pop-when-empty
// Revision: 1.0
// ---------------------------------------------------------------------------
module pc_ret_stack
   import pc_pkg::*;
#(
   parameter int WIDTH = 6,
   parameter int DEPTH = 4,
   localparam int DW   = depth_bits(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] top,
   output logic [DW-1:0]    depth,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DW-1:0]    cnt;

   assign depth = cnt;
   assign full  = (cnt == DW'(DEPTH));
   assign empty = (cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (pop && !empty) begin
         cnt <= cnt - DW'(1);
      end else if (push && !full) begin
         cnt <= cnt + DW'(1);
      end
   end

   // Storage needs no reset: entries above the depth pointer are never read.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (rst && !clr && !pop && push && !full && cnt == DW'(i)) begin
            mem[i] <= din;
         end
      end
   end

   always_comb begin
      top = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (cnt == DW'(i + 1)) begin
            top = mem[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pc_stack_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_stack_seq : program counter with jump, relative branch and call/return
// Revision: 1.0
// ---------------------------------------------------------------------------
module pc_stack_seq
   import pc_pkg::*;
#(
   parameter int ADDR_W      = 6,
   parameter int DATA_W      = 16,
   parameter int OFF_W       = 6,
   parameter int STACK_DEPTH = 4,
   parameter int START_ADDR  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] bus,
   input  logic              start,
   input  logic              stall,
   input  logic              inc_pc,
   input  logic              load,
   input  logic              branch,
   input  logic              call,
   input  logic              ret,
   output logic [ADDR_W-1:0] address,
   output logic              stack_full,
   output logic              stack_empty,
   output logic              ovf_err,
   output logic              unf_err
);

   localparam int DW = depth_bits(STACK_DEPTH);

   pc_op_t            op;
   logic [ADDR_W-1:0] next_seq;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0] stack_top;
   logic [DW-1:0]     stack_depth;
   logic              push;
   logic              pop;
   logic              unused_bits;

   assign op       = decode_op(start, stall, ret, call, load, branch, inc_pc);
   assign next_seq = address + ADDR_W'(1);
   assign target   = bus[ADDR_W-1:0];
   assign push     = (op == OP_CALL) && !stack_full;
   assign pop      = (op == OP_RET) && !stack_empty;

   assign unused_bits = ^{bus, stack_depth};

   if (OFF_W >= ADDR_W) begin : g_off_trunc
      assign offset = bus[ADDR_W-1:0];
   end else begin : g_off_sext
      assign offset = {{(ADDR_W - OFF_W){bus[OFF_W-1]}}, bus[OFF_W-1:0]};
   end

   pc_ret_stack #(
      .WIDTH (ADDR_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .clr   (op == OP_START),
      .din   (next_seq),
      .top   (stack_top),
      .depth (stack_depth),
      .full  (stack_full),
      .empty (stack_empty)
   );

   // A faulting call/ret still advances sequentially so fetch never stalls.
   always_ff @(posedge clk) begin
      if (!rst) begin
         address <= '0;
         ovf_err <= 1'b0;
         unf_err <= 1'b0;
      end else begin
         case (op)
            OP_START: begin
               address <= ADDR_W'(START_ADDR);
               ovf_err <= 1'b0;
               unf_err <= 1'b0;
            end
            OP_RET: begin
               if (stack_empty) begin
                  address <= next_seq;
                  unf_err <= 1'b1;
               end else begin
                  address <= stack_top;
               end
            end
            OP_CALL: begin
               if (stack_full) begin
                  address <= next_seq;
                  ovf_err <= 1'b1;
               end else begin
                  address <= target;
               end
            end
            OP_LOAD:   address <= target;
            OP_BRANCH: address <= address + offset;
            OP_INC:    address <= next_seq;
            default:   address <= address;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pc_stack_seq : directed and random stimulus against a queue-based model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pc_stack_seq;

   localparam int AW    = 6;
   localparam int DEPTH = 4;
   localparam int START = 1;
   localparam int MODN  = 1 << AW;

   // Control vector order: {start, stall, ret, call, load, branch, inc_pc}
   localparam logic [6:0] K_HOLD  = 7'b000_0000;
   localparam logic [6:0] K_INC   = 7'b000_0001;
   localparam logic [6:0] K_BR    = 7'b000_0010;
   localparam logic [6:0] K_LD    = 7'b000_0100;
   localparam logic [6:0] K_CALL  = 7'b000_1000;
   localparam logic [6:0] K_RET   = 7'b001_0000;
   localparam logic [6:0] K_STALL = 7'b010_0000;
   localparam logic [6:0] K_START = 7'b100_0000;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   bus;
   logic          start, stall, inc_pc, load, branch, call, ret;
   logic [AW-1:0] address;
   logic          stack_full, stack_empty, ovf_err, unf_err;

   always #5 clk = ~clk;

   pc_stack_seq dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .start       (start),
      .stall       (stall),
      .inc_pc      (inc_pc),
      .load        (load),
      .branch      (branch),
      .call        (call),
      .ret         (ret),
      .address     (address),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .ovf_err     (ovf_err),
      .unf_err     (unf_err)
   );

   int checks = 0;
   int errors = 0;

   int m_addr = 0;
   int m_stack[$];
   bit m_ovf = 1'b0;
   bit m_unf = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int wrap(input int v);
      return ((v % MODN) + MODN) % MODN;
   endfunction

   task automatic model(input logic r, input logic [6:0] ctl, input logic [15:0] b);
      int off;
      if (!r) begin
         m_addr = 0; m_stack.delete(); m_ovf = 0; m_unf = 0;
      end else if (ctl[6]) begin
         m_addr = START; m_stack.delete(); m_ovf = 0; m_unf = 0;
      end else if (ctl[5]) begin
         // hold everything
      end else if (ctl[4]) begin
         if (m_stack.size() > 0) m_addr = m_stack.pop_back();
         else begin m_addr = wrap(m_addr + 1); m_unf = 1; end
      end else if (ctl[3]) begin
         if (m_stack.size() < DEPTH) begin
            m_stack.push_back(wrap(m_addr + 1));
            m_addr = int'(b) % MODN;
         end else begin
            m_addr = wrap(m_addr + 1); m_ovf = 1;
         end
      end else if (ctl[2]) begin
         m_addr = int'(b) % MODN;
      end else if (ctl[1]) begin
         off = int'(b) % 64;
         if (off >= 32) off -= 64;
         m_addr = wrap(m_addr + off);
      end else if (ctl[0]) begin
         m_addr = wrap(m_addr + 1);
      end
   endtask

   task automatic step(input logic r, input logic [6:0] ctl, input logic [15:0] b);
      rst = r;
      {start, stall, ret, call, load, branch, inc_pc} = ctl;
      bus = b;
      @(posedge clk);
      model(r, ctl, b);
      #1;
      chk("address", 32'(address), 32'(m_addr));
      chk("stack_full", 32'(stack_full), 32'(m_stack.size() == DEPTH));
      chk("stack_empty", 32'(stack_empty), 32'(m_stack.size() == 0));
      chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
      chk("unf_err", 32'(unf_err), 32'(m_unf));
   endtask

   initial begin
      logic        rv;
      logic [6:0]  cv;
      logic [15:0] bv;

      rst = 1'b0; bus = '0;
      {start, stall, ret, call, load, branch, inc_pc} = K_HOLD;

      step(1'b0, K_HOLD, 16'h0);
      chk("reset_addr", 32'(address), 32'd0);
      chk("reset_empty", 32'(stack_empty), 32'd1);

      step(1'b1, K_START, 16'h0);
      chk("start_addr", 32'(address), 32'd1);
      repeat (62) step(1'b1, K_INC, 16'h0);
      chk("inc_to_63", 32'(address), 32'd63);
      step(1'b1, K_INC, 16'h0);
      chk("inc_wrap", 32'(address), 32'd0);

      step(1'b1, K_LD, 16'hFF0A);
      chk("load_10", 32'(address), 32'd10);
      step(1'b1, K_CALL, 16'h0023);
      chk("call_35", 32'(address), 32'd35);
      step(1'b1, K_RET, 16'h0);
      chk("ret_11", 32'(address), 32'd11);

      step(1'b1, K_LD, 16'h0005);
      step(1'b1, K_BR, 16'h003D);
      chk("branch_neg", 32'(address), 32'd2);
      step(1'b1, K_LD, 16'h003E);
      step(1'b1, K_BR, 16'h0004);
      chk("branch_wrap", 32'(address), 32'd2);

      step(1'b1, K_START, 16'h0);
      step(1'b1, K_CALL, 16'd20);
      step(1'b1, K_CALL, 16'd30);
      step(1'b1, K_CALL, 16'd40);
      step(1'b1, K_CALL, 16'd50);
      chk("full_after_4", 32'(stack_full), 32'd1);
      step(1'b1, K_CALL, 16'd60);
      chk("ovf_addr", 32'(address), 32'd51);
      chk("ovf_flag", 32'(ovf_err), 32'd1);
      step(1'b1, K_RET, 16'h0);
      chk("ret_41", 32'(address), 32'd41);
      step(1'b1, K_RET, 16'h0);
      step(1'b1, K_RET, 16'h0);
      step(1'b1, K_RET, 16'h0);
      chk("ret_2", 32'(address), 32'd2);

      step(1'b1, K_LD, 16'd7);
      step(1'b1, K_RET, 16'h0);
      chk("unf_addr", 32'(address), 32'd8);
      chk("unf_flag", 32'(unf_err), 32'd1);
      step(1'b1, K_STALL | K_INC | K_CALL, 16'd33);
      chk("stall_hold", 32'(address), 32'd8);
      step(1'b1, K_START | K_STALL, 16'h0);
      chk("start_over_stall", 32'(address), 32'd1);
      chk("start_clr_unf", 32'(unf_err), 32'd0);

      step(1'b1, K_CALL, 16'd12);
      step(1'b1, K_CALL, 16'd24);
      step(1'b0, K_CALL, 16'd36);
      chk("rst_mid_addr", 32'(address), 32'd0);
      chk("rst_mid_empty", 32'(stack_empty), 32'd1);

      step(1'b1, K_LD, 16'd17);
      rst = 1'b0;
      #3;
      chk("rst_between_edges", 32'(address), 32'd17);
      rst = 1'b1;
      step(1'b1, K_HOLD, 16'h0);

      repeat (600) begin
         rv = ($urandom_range(0, 59) != 0);
         cv[6] = ($urandom_range(0, 29) == 0);
         cv[5] = ($urandom_range(0, 5) == 0);
         for (int k = 0; k < 5; k++) cv[k] = ($urandom_range(0, 2) == 0);
         bv = 16'($urandom);
         step(rv, cv, bv);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
